// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU front-end types: fetch FSM states, IF/ID bundle, reset defaults.
// Imported by the fetch stage and its testbench.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch stage and IM.
// One request outstanding at a time; address held until accepted.
interface if_fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rvalid,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rvalid,
        output im_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding IM fetch FSM,
// one-entry stall buffer and the IF/ID pipeline register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_next_pc,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_dm_busy,
    output logic [31:0]       o_pc,
    output logic              o_im_busy,
    if_fetch_unit_if.master   im,
    output logic [31:0]       o_if_id_pc,
    output logic [31:0]       o_if_id_inst,
    output logic              o_if_id_valid
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic         r_drop;
    logic         w_drop_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_buf_pc;
    logic [31:0]  r_buf_inst;
    logic [31:0]  w_buf_pc_nxt;
    logic [31:0]  w_buf_inst_nxt;
    if_id_t       r_if_id;
    if_id_t       w_if_id_nxt;
    logic         w_hold;
    logic         w_deliver;

    assign w_hold = i_stall | i_dm_busy;

    assign w_deliver =
        ((r_state == S_WAIT) & im.im_rvalid & ~r_drop & ~i_flush & ~w_hold) |
        ((r_state == S_HOLD) & ~i_flush & ~w_hold);

    // Flush redirects even when the front end is held.
    assign w_pc_nxt = (w_deliver | i_flush) ? i_next_pc : r_pc;

    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop;
        w_buf_pc_nxt   = r_buf_pc;
        w_buf_inst_nxt = r_buf_inst;
        case (r_state)
            S_REQ: begin
                if (i_flush) w_drop_nxt = 1'b1;
                if (im.im_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (im.im_rvalid) begin
                    if (r_drop | i_flush) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (w_hold) begin
                        w_buf_pc_nxt   = r_req_addr;
                        w_buf_inst_nxt = im.im_rdata;
                        w_state_nxt    = S_HOLD;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (i_flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_flush | ~w_hold) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        w_if_id_nxt = r_if_id;
        if (i_flush) begin
            w_if_id_nxt.inst  = NOP_INST;
            w_if_id_nxt.valid = 1'b0;
        end else if (w_deliver) begin
            w_if_id_nxt.valid = 1'b1;
            if (r_state == S_HOLD) begin
                w_if_id_nxt.pc   = r_buf_pc;
                w_if_id_nxt.inst = r_buf_inst;
            end else begin
                w_if_id_nxt.pc   = r_req_addr;
                w_if_id_nxt.inst = im.im_rdata;
            end
        end else if (!w_hold) begin
            w_if_id_nxt.inst  = NOP_INST;
            w_if_id_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_drop     <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf_pc   <= '0;
            r_buf_inst <= '0;
            r_if_id    <= '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};
        end else begin
            r_state    <= w_state_nxt;
            r_drop     <= w_drop_nxt;
            r_pc       <= w_pc_nxt;
            r_buf_pc   <= w_buf_pc_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_if_id    <= w_if_id_nxt;
            // A fresh request always targets the PC as it stands after this edge.
            if (w_state_nxt == S_REQ && r_state != S_REQ)
                r_req_addr <= w_pc_nxt;
        end
    end

    assign o_pc          = r_pc;
    assign o_im_busy     = ~w_deliver;
    assign im.im_req     = (r_state == S_REQ);
    assign im.im_addr    = r_req_addr;
    assign o_if_id_pc    = r_if_id.pc;
    assign o_if_id_inst  = r_if_id.inst;
    assign o_if_id_valid = r_if_id.valid;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the architectural PC register and issues one instruction-memory request at a time.
- Captures the returned instruction into the IF/ID pipeline register.
- Sits between the PC next-address adder and the decode stage. Consumes the adder's next-PC result and supplies it the current PC, the IM busy indication and the flush-resolved PC.
- Buffers one returned instruction while the pipeline is stalled, and discards stale responses after a flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (first fetch address).
- NOP_INST, 32'h0000_0013, instruction word placed in IF/ID when a bubble or flush is inserted.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pc  in  32  next-PC value from the PC adder (target on flush, else PC+4 or held PC).
- flush  in  1  branch/jump taken; kill IF/ID and redirect.
- stall  in  1  hazard stall from decode/hazard unit.
- dm_busy  in  1  data memory busy; freezes the front end like stall.
- pc  out  32  current PC register, to the PC adder.
- im_busy  out  1  high unless an instruction is delivered into IF/ID this cycle.
- im_req  out  1  fetch request valid.
- im_addr  out  32  fetch address; stable while im_req is high and im_ready is low.
- im_ready  in  1  request accepted this cycle.
- im_rvalid  in  1  response data valid.
- im_rdata  in  32  response instruction.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_inst  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, req_addr = RESET_PC.
  - State S_REQ, drop = 0.
  - if_id_pc = 0, if_id_inst = NOP_INST, if_id_valid = 0, buffer cleared.
  - Reset mid-transaction abandons the transaction. No response from before reset is ever consumed.
- hold = stall | dm_busy.
- im_req = (state == S_REQ). im_addr = req_addr.
- At most one outstanding request.
- S_REQ:
  - on im_ready go to S_WAIT.
  - If flush arrives in this state, set drop = 1. The request keeps its address; it is not withdrawn.
- S_WAIT, on im_rvalid:
  - drop = 1, or flush this cycle: discard the data, clear drop, go to S_REQ.
  - else hold: store {req_addr, im_rdata} in the one-entry buffer, go to S_HOLD.
  - else deliver: IF/ID <= {req_addr, im_rdata, valid = 1}, go to S_REQ.
- S_WAIT, flush without im_rvalid: set drop = 1, stay in S_WAIT.
- S_HOLD:
  - flush: discard the buffer, go to S_REQ.
  - else, when hold = 0: deliver from the buffer, go to S_REQ.
- deliver = (S_WAIT & im_rvalid & ~drop & ~flush & ~hold) | (S_HOLD & ~flush & ~hold).
- im_busy = ~deliver.
- PC update:
  - pc loads next_pc when (deliver | flush); otherwise it holds.
  - flush has priority over hold.
- req_addr load: loaded with the post-edge pc value on every transition into S_REQ. After a flush it is therefore the target, with drop set if a stale request is still in flight.
- IF/ID register update:
  - flush: valid = 0, inst = NOP_INST, pc unchanged.
  - deliver: load the new instruction.
  - hold without flush: hold contents.
  - otherwise (waiting on IM, not stalled): insert a bubble, valid = 0, inst = NOP_INST.
- Simultaneous flush and stall: flush wins, so the pipeline register is cleared and the PC is redirected.
- Arithmetic: no arithmetic internally; all PC math is done in the adder.
- The PC register is 32-bit. No alignment check is done; bits [1:0] pass through unchanged.

Decomposition:
- Shared CPU package holds:
  - fetch state enum {S_REQ, S_WAIT, S_HOLD} (2-bit);
  - NOP_INST and RESET_PC default constants;
  - an if_id_t struct {pc, inst, valid}.
- No sub-module. The one-entry buffer and the FSM stay inline.

Test Plan:
- Reset release, IM returns 32'h00500093 two cycles after im_ready -> im_addr = 0. Next cycle if_id_inst = 32'h00500093, if_id_pc = 0, valid = 1. pc becomes 4 (adder gives PC+4).
- Stall high across the im_rvalid cycle, held 3 cycles -> if_id_valid stays at its old value. Instruction is delivered the cycle after stall drops. pc does not advance during the stall.
- Flush in S_WAIT with next_pc = 32'h100, response arrives later -> response discarded. Next im_addr = 32'h100, if_id_valid = 0 until the 0x100 fetch returns.
- Flush coincident with im_rvalid -> data dropped, IF/ID = NOP_INST with valid = 0. Next request is to the target.
- Flush while in S_HOLD with dm_busy = 1 -> buffer discarded, pc = target, im_req reasserts at the target next cycle.
- rst asserted mid-S_WAIT -> all outputs at reset values immediately. First request after release is to RESET_PC.
